// File: rtl/rldramii_dmaster_p2b_converter.sv
// Packets-to-bytes encoder for the debug-master byte link: serialises Avalon-ST beats into a
// byte stream framed with in-band channel/SOP/EOP markers and escape characters.
module rldramii_dmaster_p2b_converter #(
  parameter bit ALWAYS_SEND_CHANNEL = 1'b1
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  output logic       in_ready_o,
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  input  logic [7:0] in_channel_i,
  input  logic       in_startofpacket_i,
  input  logic       in_endofpacket_i,
  input  logic       out_ready_i,
  output logic       out_valid_o,
  output logic [7:0] out_data_o
);

  localparam logic [7:0] SOP_CHAR  = 8'h7A;
  localparam logic [7:0] EOP_CHAR  = 8'h7B;
  localparam logic [7:0] CHAN_CHAR = 8'h7C;
  localparam logic [7:0] ESC_CHAR  = 8'h7D;

  typedef enum logic [2:0] {
    IDLE, CHAN_MK, CHAN_ESC, CHAN_BYTE, SOP_MK, EOP_MK, DATA_ESC, DATA
  } state_e;

  state_e     state_q, state_d;
  logic       outValid_q, outValid_d;
  logic [7:0] outData_q, outData_d;
  logic [7:0] holdData_q, holdChan_q;
  logic       holdSop_q, holdEop_q;
  logic [7:0] lastChan_q;
  logic       chanVld_q;

  logic       accept, advance;
  logic [7:0] srcData, srcChan;
  logic       srcSop, srcEop, srcNeedChan;

  function automatic logic isSpecial(input logic [7:0] b);
    return (b >= SOP_CHAR) && (b <= ESC_CHAR);
  endfunction

  function automatic logic [7:0] escaped(input logic [7:0] b);
    return isSpecial(b) ? (b ^ 8'h20) : b;
  endfunction

  // Successor of 'cur' in the per-beat sequence; IDLE yields the first byte of a fresh beat.
  function automatic state_e stepAfter(input state_e cur, input logic sop, input logic eop,
                                       input logic needChan, input logic chanSpecial,
                                       input logic dataSpecial);
    state_e nxt;
    unique case (cur)
      IDLE:      nxt = needChan ? CHAN_MK : sop ? SOP_MK : eop ? EOP_MK :
                       dataSpecial ? DATA_ESC : DATA;
      CHAN_MK:   nxt = chanSpecial ? CHAN_ESC : CHAN_BYTE;
      CHAN_ESC:  nxt = CHAN_BYTE;
      CHAN_BYTE: nxt = sop ? SOP_MK : eop ? EOP_MK : dataSpecial ? DATA_ESC : DATA;
      SOP_MK:    nxt = eop ? EOP_MK : dataSpecial ? DATA_ESC : DATA;
      EOP_MK:    nxt = dataSpecial ? DATA_ESC : DATA;
      DATA_ESC:  nxt = DATA;
      default:   nxt = IDLE;
    endcase
    return nxt;
  endfunction

  function automatic logic [7:0] byteFor(input state_e s, input logic [7:0] data,
                                         input logic [7:0] chan);
    logic [7:0] b;
    unique case (s)
      CHAN_MK:            b = CHAN_CHAR;
      CHAN_ESC, DATA_ESC: b = ESC_CHAR;
      CHAN_BYTE:          b = escaped(chan);
      SOP_MK:             b = SOP_CHAR;
      EOP_MK:             b = EOP_CHAR;
      default:            b = escaped(data);
    endcase
    return b;
  endfunction

  assign in_ready_o  = (state_q == IDLE) || ((state_q == DATA) && out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign advance     = outValid_q && out_ready_i;
  assign out_valid_o = outValid_q;
  assign out_data_o  = outData_q;

  // A beat accepted this cycle is encoded straight from the inputs so its first byte has no gap.
  always_comb begin
    srcData = holdData_q;
    srcChan = holdChan_q;
    srcSop  = holdSop_q;
    srcEop  = holdEop_q;
    if (accept) begin
      srcData = in_data_i;
      srcChan = in_channel_i;
      srcSop  = in_startofpacket_i;
      srcEop  = in_endofpacket_i;
    end
    srcNeedChan = srcSop && (ALWAYS_SEND_CHANNEL || !chanVld_q || (srcChan != lastChan_q));
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = stepAfter(IDLE, srcSop, srcEop, srcNeedChan, isSpecial(srcChan),
                          isSpecial(srcData));
    end else if (advance) begin
      state_d = stepAfter(state_q, srcSop, srcEop, srcNeedChan, isSpecial(srcChan),
                          isSpecial(srcData));
    end
    outValid_d = (state_d != IDLE);
    outData_d  = (state_d == IDLE) ? outData_q : byteFor(state_d, srcData, srcChan);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      outValid_q <= 1'b0;
      outData_q  <= 8'h00;
      holdData_q <= 8'h00;
      holdChan_q <= 8'h00;
      holdSop_q  <= 1'b0;
      holdEop_q  <= 1'b0;
      lastChan_q <= 8'h00;
      chanVld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      if (accept) begin
        holdData_q <= in_data_i;
        holdChan_q <= in_channel_i;
        holdSop_q  <= in_startofpacket_i;
        holdEop_q  <= in_endofpacket_i;
      end
      if (accept && (state_d == CHAN_MK)) begin
        lastChan_q <= in_channel_i;
        chanVld_q  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rldramii_dmaster_p2b_converter.sv
// Bench for the packets-to-bytes encoder: instance 1 always sends the channel marker,
// instance 0 sends it only on a channel change.
`timescale 1ns/1ps
module tb_rldramii_dmaster_p2b_converter;

  localparam logic [7:0] SOP_B  = 8'h7A;
  localparam logic [7:0] EOP_B  = 8'h7B;
  localparam logic [7:0] CHAN_B = 8'h7C;
  localparam logic [7:0] ESC_B  = 8'h7D;

  typedef struct {
    logic [7:0]  data;
    logic [7:0]  chan;
    logic        sop;
    logic        eop;
    int          nExp;
    logic [63:0] expBytes;
  } vec_t;

  typedef struct packed {
    logic [7:0] chan;
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } beat_t;

  logic       clk = 1'b0;
  logic       resetN = 1'b1;
  logic       inValid[2];
  logic [7:0] inData[2];
  logic [7:0] inChannel[2];
  logic       inSop[2];
  logic       inEop[2];
  logic       inReady[2];
  logic       outReady[2];
  logic       outValid[2];
  logic [7:0] outData[2];
  int         readyMode[2] = '{0, 0};
  logic       rndReady[2] = '{1'b0, 1'b0};

  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] got[2][$];
  int         gotCyc[2][$];
  logic [7:0] expQ[2][$];
  beat_t      sentQ[2][$];
  logic [7:0] mLastChan[2];
  logic       mChanVld[2];
  logic       prevStall[2] = '{1'b0, 1'b0};
  logic [7:0] prevData[2];

  rldramii_dmaster_p2b_converter #(.ALWAYS_SEND_CHANNEL(1'b0)) dut0 (
    .clk_i(clk), .reset_n_i(resetN), .in_ready_o(inReady[0]), .in_valid_i(inValid[0]),
    .in_data_i(inData[0]), .in_channel_i(inChannel[0]), .in_startofpacket_i(inSop[0]),
    .in_endofpacket_i(inEop[0]), .out_ready_i(outReady[0]), .out_valid_o(outValid[0]),
    .out_data_o(outData[0])
  );

  rldramii_dmaster_p2b_converter #(.ALWAYS_SEND_CHANNEL(1'b1)) dut1 (
    .clk_i(clk), .reset_n_i(resetN), .in_ready_o(inReady[1]), .in_valid_i(inValid[1]),
    .in_data_i(inData[1]), .in_channel_i(inChannel[1]), .in_startofpacket_i(inSop[1]),
    .in_endofpacket_i(inEop[1]), .out_ready_i(outReady[1]), .out_valid_o(outValid[1]),
    .out_data_o(outData[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) rndReady[k] = 1'($urandom_range(0, 1));
  end

  always_comb begin
    for (int k = 0; k < 2; k++) outReady[k] = (readyMode[k] == 0) || rndReady[k];
  end

  function automatic bit checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      return 1'b0;
    end
    return 1'b1;
  endfunction

  // Output monitor: records every handshaken byte and checks that stalled bytes are held.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!resetN) begin
        prevStall[k] = 1'b0;
      end else begin
        if (prevStall[k]) begin
          void'(checkOutput($sformatf("stall valid hold i%0d", k), int'(outValid[k]), 1));
          void'(checkOutput($sformatf("stall data hold i%0d", k), int'(outData[k]),
                            int'(prevData[k])));
        end
        if (outValid[k] && outReady[k]) begin
          got[k].push_back(outData[k]);
          gotCyc[k].push_back(cyc);
        end
        prevStall[k] = outValid[k] && !outReady[k];
        prevData[k]  = outData[k];
      end
    end
  end

  // Expected byte stream of one beat, built directly from the framing rules.
  function automatic void pushEsc(input int k, input logic [7:0] b);
    if (b >= 8'h7A && b <= 8'h7D) begin
      expQ[k].push_back(ESC_B);
      expQ[k].push_back(b ^ 8'h20);
    end else begin
      expQ[k].push_back(b);
    end
  endfunction

  function automatic void modelBeat(input int k, input logic [7:0] d, input logic [7:0] ch,
                                    input logic s, input logic e);
    if (s && ((k == 1) || !mChanVld[k] || (ch != mLastChan[k]))) begin
      expQ[k].push_back(CHAN_B);
      pushEsc(k, ch);
      mLastChan[k] = ch;
      mChanVld[k]  = 1'b1;
    end
    if (s) expQ[k].push_back(SOP_B);
    if (e) expQ[k].push_back(EOP_B);
    pushEsc(k, d);
  endfunction

  // Offers one beat; called right after a rising edge, returns right after the accepting edge.
  task automatic applyStimulus(input int k, input logic [7:0] d, input logic [7:0] ch,
                               input logic s, input logic e, output int accCyc);
    inValid[k]   = 1'b1;
    inData[k]    = d;
    inChannel[k] = ch;
    inSop[k]     = s;
    inEop[k]     = e;
    accCyc = -1;
    for (int t = 0; t < 400 && accCyc < 0; t++) begin
      @(negedge clk);
      if (inReady[k]) begin
        @(posedge clk);
        #1;
        accCyc = cyc;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    inValid[k] = 1'b0;
    if (accCyc < 0) void'(checkOutput($sformatf("accept timeout i%0d", k), 0, 1));
  endtask

  task automatic waitDrain(input int k);
    int budget;
    budget = 20 * expQ[k].size() + 100;
    for (int t = 0; t < budget && got[k].size() < expQ[k].size(); t++) @(negedge clk);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic compareStream(input int k, input string name);
    void'(checkOutput({name, " byte count"}, got[k].size(), expQ[k].size()));
    for (int i = 0; i < got[k].size() && i < expQ[k].size(); i++)
      if (!checkOutput($sformatf("%s byte %0d", name, i), int'(got[k][i]), int'(expQ[k][i])))
        break;
  endtask

  task automatic checkGaps(input int k, input string name);
    for (int i = 1; i < gotCyc[k].size(); i++)
      if (!checkOutput($sformatf("%s gap %0d", name, i), gotCyc[k][i] - gotCyc[k][i-1], 1))
        break;
  endtask

  task automatic clearStreams(input int k);
    got[k].delete();
    gotCyc[k].delete();
    expQ[k].delete();
  endtask

  // Independent reference decoder: rebuilds beats from the byte stream.
  task automatic decodeAndCheck(input int k);
    beat_t      dq[$];
    logic       esc = 1'b0, chanNext = 1'b0, s = 1'b0, e = 1'b0, lit;
    logic [7:0] cur = 8'h00, b;
    for (int i = 0; i < got[k].size(); i++) begin
      b = got[k][i];
      lit = 1'b0;
      if (esc) begin
        b = b ^ 8'h20;
        esc = 1'b0;
        lit = 1'b1;
      end else begin
        case (b)
          ESC_B:   esc = 1'b1;
          CHAN_B:  chanNext = 1'b1;
          SOP_B:   s = 1'b1;
          EOP_B:   e = 1'b1;
          default: lit = 1'b1;
        endcase
      end
      if (lit) begin
        if (chanNext) begin
          cur = b;
          chanNext = 1'b0;
        end else begin
          dq.push_back(beat_t'({cur, b, s, e}));
          s = 1'b0;
          e = 1'b0;
        end
      end
    end
    void'(checkOutput($sformatf("decoded beat count i%0d", k), dq.size(), sentQ[k].size()));
    for (int i = 0; i < dq.size() && i < sentQ[k].size(); i++)
      if (!checkOutput($sformatf("decoded beat %0d i%0d", i, k), int'(dq[i]), int'(sentQ[k][i])))
        break;
  endtask

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation did not complete, got 0 expected 1");
    $fatal(1);
  end

  initial begin
    vec_t       vecs[9];
    int         acc, acc0, len;
    int         accArr[16];
    logic [7:0] ch, d;
    logic       s, e;

    vecs[0] = '{data:8'h11, chan:8'h03, sop:1'b1, eop:1'b0, nExp:4, expBytes:64'h7C037A11_00000000};
    vecs[1] = '{data:8'h22, chan:8'h55, sop:1'b0, eop:1'b0, nExp:1, expBytes:64'h22000000_00000000};
    vecs[2] = '{data:8'h33, chan:8'h66, sop:1'b0, eop:1'b1, nExp:2, expBytes:64'h7B330000_00000000};
    vecs[3] = '{data:8'h7D, chan:8'h7B, sop:1'b1, eop:1'b1, nExp:7, expBytes:64'h7C7D5B7A_7B7D5D00};
    vecs[4] = '{data:8'h7A, chan:8'h00, sop:1'b0, eop:1'b0, nExp:2, expBytes:64'h7D5A0000_00000000};
    vecs[5] = '{data:8'h79, chan:8'h00, sop:1'b0, eop:1'b0, nExp:1, expBytes:64'h79000000_00000000};
    vecs[6] = '{data:8'h7E, chan:8'h00, sop:1'b0, eop:1'b1, nExp:2, expBytes:64'h7B7E0000_00000000};
    vecs[7] = '{data:8'h00, chan:8'h7C, sop:1'b1, eop:1'b0, nExp:5, expBytes:64'h7C7D5C7A_00000000};
    vecs[8] = '{data:8'h7B, chan:8'h7D, sop:1'b1, eop:1'b1, nExp:7, expBytes:64'h7C7D5D7A_7B7D5B00};

    for (int k = 0; k < 2; k++) begin
      inValid[k] = 1'b0; inData[k] = 8'h00; inChannel[k] = 8'h00;
      inSop[k] = 1'b0; inEop[k] = 1'b0;
    end

    $display("[TB] reset state");
    #2 resetN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      void'(checkOutput($sformatf("reset out_valid i%0d", k), int'(outValid[k]), 0));
      void'(checkOutput($sformatf("reset out_data i%0d", k), int'(outData[k]), 0));
      void'(checkOutput($sformatf("reset in_ready i%0d", k), int'(inReady[k]), 1));
    end
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] three-beat packet, channel always sent");
    clearStreams(1);
    expQ[1] = {8'h7C, 8'h03, 8'h7A, 8'h11, 8'h22, 8'h7B, 8'h33};
    applyStimulus(1, 8'h11, 8'h03, 1'b1, 1'b0, acc0);
    applyStimulus(1, 8'h22, 8'h03, 1'b0, 1'b0, acc);
    applyStimulus(1, 8'h33, 8'h03, 1'b0, 1'b1, acc);
    waitDrain(1);
    compareStream(1, "pkt");
    checkGaps(1, "pkt");
    void'(checkOutput("pkt first byte cycle", (gotCyc[1].size() > 0) ? gotCyc[1][0] : -1, acc0));

    $display("[TB] single-beat vector table");
    for (int v = 0; v < 9; v++) begin
      clearStreams(1);
      for (int i = 0; i < vecs[v].nExp; i++) expQ[1].push_back(vecs[v].expBytes[63-8*i -: 8]);
      applyStimulus(1, vecs[v].data, vecs[v].chan, vecs[v].sop, vecs[v].eop, acc);
      waitDrain(1);
      compareStream(1, $sformatf("vec%0d", v));
    end

    $display("[TB] streaming plain beats");
    clearStreams(1);
    for (int i = 0; i < 16; i++) begin
      expQ[1].push_back(8'(i));
      applyStimulus(1, 8'(i), 8'h00, 1'b0, 1'b0, accArr[i]);
    end
    waitDrain(1);
    compareStream(1, "stream");
    checkGaps(1, "stream");
    for (int i = 1; i < 16; i++)
      if (!checkOutput($sformatf("stream accept spacing %0d", i), accArr[i] - accArr[i-1], 1))
        break;

    $display("[TB] channel marker only on change");
    clearStreams(0);
    expQ[0] = {8'h7C, 8'h05, 8'h7A, 8'h7B, 8'h01,
               8'h7A, 8'h7B, 8'h02,
               8'h7C, 8'h06, 8'h7A, 8'h7B, 8'h03};
    applyStimulus(0, 8'h01, 8'h05, 1'b1, 1'b1, acc);
    applyStimulus(0, 8'h02, 8'h05, 1'b1, 1'b1, acc);
    applyStimulus(0, 8'h03, 8'h06, 1'b1, 1'b1, acc);
    waitDrain(0);
    compareStream(0, "chan-change");

    $display("[TB] reset in the middle of a beat");
    clearStreams(0);
    expQ[0] = {8'h7C, 8'h02, 8'h7A, 8'h7B, 8'h10};
    applyStimulus(0, 8'h10, 8'h02, 1'b1, 1'b1, acc);
    waitDrain(0);
    compareStream(0, "pre-reset");
    clearStreams(1);
    applyStimulus(1, 8'h55, 8'h09, 1'b1, 1'b0, acc);
    for (int t = 0; t < 20 && got[1].size() == 0; t++) @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    for (int k = 0; k < 2; k++)
      void'(checkOutput($sformatf("valid drops at reset i%0d", k), int'(outValid[k]), 0));
    void'(checkOutput("aborted beat first byte", (got[1].size() > 0) ? int'(got[1][0]) : -1, 8'h7C));
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      void'(checkOutput($sformatf("in reset out_valid i%0d", k), int'(outValid[k]), 0));
      void'(checkOutput($sformatf("in reset in_ready i%0d", k), int'(inReady[k]), 1));
    end
    resetN = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      clearStreams(k);
      expQ[k] = {8'h7C, 8'h02, 8'h7A, 8'h7B, 8'h44};
      mLastChan[k] = 8'h02;
      mChanVld[k]  = 1'b1;
    end
    applyStimulus(1, 8'h44, 8'h02, 1'b1, 1'b1, acc);
    applyStimulus(0, 8'h44, 8'h02, 1'b1, 1'b1, acc);
    waitDrain(1);
    waitDrain(0);
    compareStream(1, "post-reset i1");
    compareStream(0, "post-reset i0");

    $display("[TB] random packets under backpressure");
    for (int k = 0; k < 2; k++) begin
      clearStreams(k);
      sentQ[k].delete();
      readyMode[k] = 1;
      for (int p = 0; p < 100; p++) begin
        len = $urandom_range(1, 4);
        ch = ($urandom_range(0, 3) == 0) ? 8'(8'h7A + $urandom_range(0, 3))
                                          : 8'($urandom_range(0, 2));
        for (int b = 0; b < len; b++) begin
          d = ($urandom_range(0, 3) == 0) ? 8'(8'h7A + $urandom_range(0, 3))
                                           : 8'($urandom_range(0, 255));
          s = (b == 0);
          e = (b == len - 1);
          modelBeat(k, d, ch, s, e);
          sentQ[k].push_back(beat_t'({ch, d, s, e}));
          applyStimulus(k, d, s ? ch : 8'($urandom_range(0, 255)), s, e, acc);
        end
      end
      waitDrain(k);
      readyMode[k] = 0;
      compareStream(k, $sformatf("random i%0d", k));
      decodeAndCheck(k);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
